booth_multi: RTL and testbench
==============================

Name: booth_multi

Overview:
- Signed two's-complement multiplier: 32-bit operands A and B, full-precision 64-bit product.
- Internally a radix-4 (modified) Booth recoder, partial-product array and adder tree, followed by one output register.
- Used as the multiply primitive of the ALU datapath.
- Free-running: no handshake. A new operand pair can be applied every cycle.

Parameters:
- WIDTH, 32: operand width in bits. Must be even and at least 4. Result width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- A  input  WIDTH  multiplicand, signed two's complement
- B  input  WIDTH  multiplier, signed two's complement
- Result  output  2*WIDTH  signed product A*B, registered

Behaviour:
- One clock; reset is synchronous and active-high. On a rising clk edge with rst=1, Result <= 0. rst takes priority over the operand inputs.
- Latency is 1 cycle. At every rising edge with rst=0, Result <= A*B, computed combinationally from the A and B values present just before that edge. Result holds until the next edge.
- Throughput is 1 product per cycle. There are no stall or enable inputs.
- Reset mid-stream: the product in flight is discarded. The first edge after rst falls loads A*B of the inputs present at that edge.
- Arithmetic is exact signed multiplication. Both operands are sign-extended to 2*WIDTH, and the product always fits in 2*WIDTH bits, so overflow is impossible.
- Corner case: (-2^(WIDTH-1)) * (-2^(WIDTH-1)) = +2^(2*WIDTH-2) is representable and must be exact.
- Booth recoding:
  - Append an implicit 0 below B[0] and sign-extend B as needed.
  - Take overlapping 3-bit groups {B[2i+1], B[2i], B[2i-1]} for i = 0..WIDTH/2-1.
  - Each group selects a digit in {0, +A, +2A, -A, -2A}:
    - 000 and 111 give 0
    - 001 and 010 give +A
    - 011 gives +2A
    - 100 gives -2A
    - 101 and 110 give -A
  - Negation is one's complement plus an injected 1 at the partial product's LSB.
- Partial product i:
  - Sign-extended to 2*WIDTH bits, then shifted left by 2i.
  - There are WIDTH/2 partial products (16 at WIDTH=32).
  - They are summed modulo 2^(2*WIDTH). Adder structure (CSA/Wallace tree or ripple chain) is implementer's choice, provided the combinational path closes at the target clock.
- Zero handling: if either operand is 0, Result = 0.
- Multiplication by 1 returns the other operand sign-extended.
- Output contains no X after reset, even with X-free but arbitrary inputs.
- No other internal state exists.

Test Plan:
- Reset, then A=1, B=-90 for one edge -> Result = 64'hFFFF_FFFF_FFFF_FFA6 (-90). Also A=1, B=-2432 -> -2432.
- A=5, B=5 -> 25. A=234, B=345 -> 80730. A=13, B=10 -> 130. Each result appears exactly one edge after the inputs are applied.
- Signs:
  - A=-5, B=-7 -> 35.
  - A=-5, B=7 -> -35.
  - A=0, B=-24 -> 0.
- Extremes:
  - A=B=32'h8000_0000 -> 64'h4000_0000_0000_0000.
  - A=32'h7FFF_FFFF, B=32'h8000_0000 -> 64'hC000_0000_8000_0000.
  - A=B=-1 -> 1.
- Back-to-back and reset:
  - Change A/B every cycle and check each Result against a reference model, 1-cycle delayed.
  - Assert rst mid-stream -> Result = 0 on that edge. The next edge after release shows the product of the current inputs.
- Random regression: at least 10,000 random signed pairs, including operands forced to 0, ±1 and ±2^31. Result must equal $signed(A)*$signed(B) every cycle.

Source files
------------

// File: rtl/booth_multi.sv
// Signed radix-4 Booth multiplier with a single registered output stage.
// Result is A*B of the operands sampled at the previous rising edge.
module booth_multi #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Result
);

    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned NPP = WIDTH / 2;

    logic [WIDTH:0]  w_b_ext;
    logic [PW-1:0]   w_a_ext;
    logic [PW-1:0]   w_a2_ext;
    logic [PW-1:0]   w_pp [NPP];
    logic [PW-1:0]   w_sum;
    logic [PW-1:0]   r_result;

    // Implicit zero below B[0]; A sign-extended to full product width.
    assign w_b_ext  = {B, 1'b0};
    assign w_a_ext  = {{WIDTH{A[WIDTH-1]}}, A};
    assign w_a2_ext = {w_a_ext[PW-2:0], 1'b0};

    for (genvar gi = 0; gi < NPP; gi++) begin : g_pp
        logic [2:0]    w_grp;
        logic [PW-1:0] w_mag;
        logic          w_neg;
        logic [PW-1:0] w_digit;

        assign w_grp = w_b_ext[2*gi +: 3];

        // Booth digit select: magnitude and sign of {0, A, 2A}.
        always_comb begin
            w_mag = '0;
            w_neg = 1'b0;
            case (w_grp)
                3'b001, 3'b010: w_mag = w_a_ext;
                3'b011:         w_mag = w_a2_ext;
                3'b100: begin
                    w_mag = w_a2_ext;
                    w_neg = 1'b1;
                end
                3'b101, 3'b110: begin
                    w_mag = w_a_ext;
                    w_neg = 1'b1;
                end
                default:        w_mag = '0;
            endcase
        end

        // Negation as one's complement plus an injected LSB carry.
        assign w_digit  = (w_neg ? ~w_mag : w_mag) + PW'(w_neg);
        assign w_pp[gi] = w_digit << (2 * gi);
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < int'(NPP); i++) begin
            w_sum = w_sum + w_pp[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
        end else begin
            r_result <= w_sum;
        end
    end

    assign Result = r_result;

endmodule

// File: tb/tb_booth_multi.sv
// Self-checking bench for booth_multi: directed literals plus a randomized
// stream compared every cycle against a plain-arithmetic product model.
module tb_booth_multi;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [63:0] Result;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] model_res;
    logic [31:0] model_a;
    logic [31:0] model_b;
    logic        model_valid = 1'b0;

    booth_multi #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .Result (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what each edge must load, from plain signed arithmetic.
    always @(posedge clk) begin
        model_a = A;
        model_b = B;
        if (rst)
            model_res = 64'd0;
        else
            model_res = 64'(longint'($signed(A)) * longint'($signed(B)));
        model_valid = 1'b1;
    end

    // Compare process: checks every cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            n_checks++;
            if ($isunknown(Result) || Result !== model_res) begin
                n_errors++;
                $display("FAIL stream t=%0t A=%h B=%h got=%h exp=%h",
                         $time, model_a, model_b, Result, model_res);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] a,
                       input logic [31:0] b, input logic r,
                       input logic [63:0] exp);
        @(negedge clk);
        A   = a;
        B   = b;
        rst = r;
        @(posedge clk);
        #1;
        n_checks++;
        if (Result !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, Result, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0000_0000;
            1:       v = 32'h0000_0001;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        A   = 32'h1234_5678;
        B   = 32'h9ABC_DEF0;
        lit("reset", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 64'd0);

        lit("one_x_m90",   32'd1,   -32'sd90,   1'b0, 64'hFFFF_FFFF_FFFF_FFA6);
        lit("one_x_m2432", 32'd1,   -32'sd2432, 1'b0, 64'hFFFF_FFFF_FFFF_F680);
        lit("5x5",         32'd5,   32'd5,      1'b0, 64'd25);
        lit("234x345",     32'd234, 32'd345,    1'b0, 64'd80730);
        lit("13x10",       32'd13,  32'd10,     1'b0, 64'd130);
        lit("m5xm7",       -32'sd5, -32'sd7,    1'b0, 64'd35);
        lit("m5x7",        -32'sd5, 32'd7,      1'b0, 64'hFFFF_FFFF_FFFF_FFDD);
        lit("0xm24",       32'd0,   -32'sd24,   1'b0, 64'd0);
        lit("min_x_min",   32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
        lit("max_x_min",   32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 64'hC000_0000_8000_0000);
        lit("m1xm1",       32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'd1);
        lit("midrst",      32'd5,   32'd5,      1'b1, 64'd0);
        lit("after_rst",   32'd3,   -32'sd4,    1'b0, 64'hFFFF_FFFF_FFFF_FFF4);

        // Back-to-back random stream with occasional mid-stream resets.
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            A   = pick();
            B   = pick();
            rst = ((i % 997) == 500);
        end

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
